// File: rtl/branch_resolve_pkg.sv
// branch_resolve_pkg: opcode, funct3 and FSM state constants shared by the branch resolver.
package branch_resolve_pkg;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;
endpackage

// File: rtl/branch_cond.sv
// branch_cond: opcode/funct3 plus comparator flags to raw taken decision (ungated).
module branch_cond
  import branch_resolve_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_breq,
  input  logic       i_brlt,
  output logic       o_taken
);
  logic w_br;
  always_comb begin
    w_br = (i_funct3 == F3_BEQ) ? i_breq :
           (i_funct3 == F3_BNE) ? !i_breq :
           (i_funct3 == F3_BLT || i_funct3 == F3_BLTU) ? i_brlt :
           (i_funct3 == F3_BGE || i_funct3 == F3_BGEU) ? !i_brlt : 1'b0;
    o_taken = (i_opcode == OP_BRANCH) ? w_br : (i_opcode == OP_JAL || i_opcode == OP_JALR);
  end
endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: EX-stage branch/jump resolution, one-cycle redirect and FLUSH_CYCLES-long IF/ID squash.
// Optional BRANCH_STATS_EN adds conditional-branch resolved/taken counters.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_stall,
  input  logic [6:0]  ex_opcode,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_target,
  input  logic        breq,
  input  logic        brlt,
  output logic        brun,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush_if,
  output logic        flush_id,
  output logic        br_taken
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0] br_count,
  output logic [31:0] br_taken_count
`endif
);
  logic       w_cond;
  logic       w_idle;
  logic       w_last;
  logic [0:0] r_state;
  logic [2:0] r_cnt;
  branch_cond u_cond (
    .i_opcode(ex_opcode),
    .i_funct3(ex_funct3),
    .i_breq  (breq),
    .i_brlt  (brlt),
    .o_taken (w_cond)
  );
  assign brun     = ex_funct3[1];
  assign w_idle   = r_state == ST_IDLE;
  assign w_last   = r_cnt == 3'(FLUSH_CYCLES - 1);
  assign br_taken = ex_valid & !ex_stall & w_idle & w_cond;
  assign flush_if = r_state == ST_FLUSH;
  assign flush_id = flush_if;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= br_taken;
      if (br_taken)
        redirect_pc <= (ex_opcode == OP_JALR) ? {ex_target[31:1], 1'b0} : ex_target;
      if (br_taken) begin
        r_state <= ST_FLUSH;
        r_cnt   <= '0;
      end else if (!w_idle && !ex_stall) begin
        r_state <= w_last ? ST_IDLE : ST_FLUSH;
        r_cnt   <= w_last ? 3'd0 : r_cnt + 3'd1;
      end
    end
  end
`ifdef BRANCH_STATS_EN
  logic w_resolve;
  assign w_resolve = ex_valid & !ex_stall & w_idle & (ex_opcode == OP_BRANCH);
  always_ff @(posedge clk) begin
    if (rst) begin
      br_count       <= '0;
      br_taken_count <= '0;
    end else begin
      if (w_resolve) br_count <= br_count + 32'd1;
      if (w_resolve && w_cond) br_taken_count <= br_taken_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: scenario tasks with a redirect-address scoreboard queue.
module tb_branch_resolve;
  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_stall;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_target;
  logic        breq;
  logic        brlt;
  logic        brun;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush_if;
  logic        flush_id;
  logic        br_taken;
`ifdef BRANCH_STATS_EN
  logic [31:0] br_count;
  logic [31:0] br_taken_count;
`endif
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_bc = 0;
  logic [31:0] exp_btc = 0;

  branch_resolve #(.FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_stall(ex_stall),
    .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_target(ex_target),
    .breq(breq), .brlt(brlt), .brun(brun), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush_if(flush_if), .flush_id(flush_id),
    .br_taken(br_taken)
`ifdef BRANCH_STATS_EN
    , .br_count(br_count), .br_taken_count(br_taken_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic model_taken(input logic [6:0] op, input logic [2:0] f3,
                                       input logic eq, input logic lt);
    if (op == 7'b1101111 || op == 7'b1100111) return 1'b1;
    if (op != 7'b1100011) return 1'b0;
    case (f3)
      3'b000: return eq;
      3'b001: return !eq;
      3'b100, 3'b110: return lt;
      3'b101, 3'b111: return !lt;
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    ex_valid = 0; ex_stall = 0; breq = 0; brlt = 0;
    ex_opcode = 7'h13; ex_funct3 = 3'b000; ex_target = 32'h0;
  endtask

  // Drives one live EX instruction from IDLE and records what the model expects of it.
  task automatic fire(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] tgt,
                      input logic eq, input logic lt, output logic t);
    ex_valid = 1; ex_stall = 0; ex_opcode = op; ex_funct3 = f3;
    ex_target = tgt; breq = eq; brlt = lt;
    #1;
    t = model_taken(op, f3, eq, lt);
    if (t) exp_q.push_back(op == 7'b1100111 ? {tgt[31:1], 1'b0} : tgt);
    if (op == 7'b1100011) begin
      exp_bc++;
      if (t) exp_btc++;
    end
  endtask

  task automatic observe(input int n, output int nf, output int nr, output logic [31:0] pc,
                         output int ndiff);
    nf = 0; nr = 0; pc = 32'h0; ndiff = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      idle();
      if (redirect_valid) begin nr++; pc = redirect_pc; end
      if (flush_if) nf++;
      if (flush_if !== flush_id) ndiff++;
    end
  endtask

  task automatic test_reset;
    idle();
    rst = 1;
    tick();
    tick();
    n_chk++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rv: got %b want 0", redirect_valid); end
    n_chk++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", redirect_pc); end
    n_chk++; if ({flush_if, flush_id} !== 2'b00) begin n_fail++; $display("FAIL reset_flush: got %b%b want 00", flush_if, flush_id); end
    rst = 0;
  endtask

  task automatic test_beq;
    logic t;
    logic [31:0] e;
    fire(7'b1100011, 3'b000, 32'h100, 1, 0, t);
    n_chk++; if (br_taken !== 1'b1 || t !== 1'b1) begin n_fail++; $display("FAIL beq_taken: got %b want 1", br_taken); end
    tick();
    idle();
    e = exp_q.pop_front();
    n_chk++; if (redirect_valid !== 1'b1 || redirect_pc !== e) begin n_fail++; $display("FAIL beq_redirect: got %b/%h want 1/%h", redirect_valid, redirect_pc, e); end
    n_chk++; if ({flush_if, flush_id} !== 2'b11) begin n_fail++; $display("FAIL beq_flush1: got %b%b want 11", flush_if, flush_id); end
    tick();
    n_chk++; if (redirect_valid !== 1'b0 || {flush_if, flush_id} !== 2'b11) begin n_fail++; $display("FAIL beq_cycle2: got rv=%b fl=%b%b want rv=0 fl=11", redirect_valid, flush_if, flush_id); end
    tick();
    n_chk++; if ({flush_if, flush_id} !== 2'b00) begin n_fail++; $display("FAIL beq_flush_end: got %b%b want 00", flush_if, flush_id); end
    n_chk++; if (redirect_pc !== 32'h100) begin n_fail++; $display("FAIL beq_pc_hold: got %h want 00000100", redirect_pc); end
  endtask

  task automatic test_bltu;
    logic t;
    int nf, nr, nd;
    logic [31:0] pc, e;
    fire(7'b1100011, 3'b110, 32'h300, 0, 0, t);
    n_chk++; if (brun !== 1'b1) begin n_fail++; $display("FAIL bltu_brun: got %b want 1", brun); end
    n_chk++; if (br_taken !== t) begin n_fail++; $display("FAIL bltu_nt_taken: got %b want %b", br_taken, t); end
    observe(4, nf, nr, pc, nd);
    n_chk++; if (nr != 0 || nf != 0) begin n_fail++; $display("FAIL bltu_nt_quiet: got redirects=%0d flush=%0d want 0/0", nr, nf); end
    fire(7'b1100011, 3'b110, 32'h304, 0, 1, t);
    n_chk++; if (br_taken !== t) begin n_fail++; $display("FAIL bltu_t_taken: got %b want %b", br_taken, t); end
    observe(4, nf, nr, pc, nd);
    e = exp_q.pop_front();
    n_chk++; if (nr != 1 || nf != 2 || pc !== e || nd != 0) begin n_fail++; $display("FAIL bltu_t_redirect: got n=%0d fl=%0d pc=%h want 1/2/%h", nr, nf, pc, e); end
  endtask

  task automatic test_jump;
    logic t;
    int nf, nr, nd;
    logic [31:0] pc, e;
    fire(7'b1100111, 3'b000, 32'h203, 0, 0, t);
    n_chk++; if (br_taken !== 1'b1 || brun !== 1'b0) begin n_fail++; $display("FAIL jalr_decode: got taken=%b brun=%b want 1/0", br_taken, brun); end
    observe(4, nf, nr, pc, nd);
    e = exp_q.pop_front();
    n_chk++; if (nr != 1 || pc !== e || e !== 32'h202) begin n_fail++; $display("FAIL jalr_pc: got %h want 00000202", pc); end
    fire(7'b1101111, 3'b000, 32'h401, 0, 0, t);
    observe(4, nf, nr, pc, nd);
    e = exp_q.pop_front();
    n_chk++; if (nr != 1 || nf != 2 || pc !== e) begin n_fail++; $display("FAIL jal_pc: got n=%0d fl=%0d pc=%h want 1/2/%h", nr, nf, pc, e); end
  endtask

  task automatic test_cond_table;
    logic t;
    int nf, nr, nd;
    logic [31:0] pc, e;
    for (int f = 0; f < 8; f++) begin
      for (int c = 0; c < 4; c++) begin
        fire(7'b1100011, 3'(f), $urandom & 32'hffff_fffc, c[0], c[1], t);
        n_chk++; if (br_taken !== t) begin n_fail++; $display("FAIL cond_f3_%0d_c%0d_taken: got %b want %b", f, c, br_taken, t); end
        observe(4, nf, nr, pc, nd);
        e = t ? exp_q.pop_front() : 32'h0;
        n_chk++; if (nr != int'(t) || nf != (t ? 2 : 0) || (t && pc !== e)) begin n_fail++; $display("FAIL cond_f3_%0d_c%0d_redirect: got n=%0d fl=%0d pc=%h want %0d/%0d/%h", f, c, nr, nf, pc, t, t ? 2 : 0, e); end
      end
    end
    fire(7'b0110011, 3'b000, 32'h999, 1, 1, t);
    n_chk++; if (br_taken !== 1'b0) begin n_fail++; $display("FAIL other_opcode: got %b want 0", br_taken); end
    observe(3, nf, nr, pc, nd);
    ex_valid = 0; ex_opcode = 7'b1101111; ex_target = 32'h500;
    #1;
    n_chk++; if (br_taken !== 1'b0) begin n_fail++; $display("FAIL gate_valid: got %b want 0", br_taken); end
    ex_valid = 1; ex_stall = 1;
    #1;
    n_chk++; if (br_taken !== 1'b0) begin n_fail++; $display("FAIL gate_stall: got %b want 0", br_taken); end
    observe(3, nf, nr, pc, nd);
    n_chk++; if (nr != 0 || nf != 0) begin n_fail++; $display("FAIL gate_quiet: got n=%0d fl=%0d want 0/0", nr, nf); end
  endtask

  task automatic test_flush_ignore;
    logic t;
    logic [31:0] e;
    fire(7'b1100011, 3'b000, 32'h500, 1, 0, t);
    tick();
    ex_opcode = 7'b1100011; ex_funct3 = 3'b001; breq = 0; ex_target = 32'h600;
    #1;
    e = exp_q.pop_front();
    n_chk++; if (redirect_valid !== 1'b1 || redirect_pc !== e) begin n_fail++; $display("FAIL ignore_first: got %b/%h want 1/%h", redirect_valid, redirect_pc, e); end
    n_chk++; if (br_taken !== 1'b0) begin n_fail++; $display("FAIL ignore_taken1: got %b want 0", br_taken); end
    tick();
    n_chk++; if (br_taken !== 1'b0 || redirect_valid !== 1'b0 || flush_if !== 1'b1) begin n_fail++; $display("FAIL ignore_cycle2: got t=%b rv=%b fl=%b want 0/0/1", br_taken, redirect_valid, flush_if); end
    idle();
    tick();
    n_chk++; if (redirect_valid !== 1'b0 || flush_if !== 1'b0 || redirect_pc !== 32'h500) begin n_fail++; $display("FAIL ignore_end: got rv=%b fl=%b pc=%h want 0/0/00000500", redirect_valid, flush_if, redirect_pc); end
  endtask

  task automatic test_stall;
    logic t;
    int nf, nr;
    logic [31:0] e;
    fire(7'b1100011, 3'b101, 32'h700, 0, 0, t);
    tick();
    idle();
    e = exp_q.pop_front();
    n_chk++; if (redirect_valid !== 1'b1 || redirect_pc !== e) begin n_fail++; $display("FAIL stall_redirect: got %b/%h want 1/%h", redirect_valid, redirect_pc, e); end
    nf = 0; nr = 0;
    for (int i = 0; i < 10; i++) begin
      if (flush_if) nf++;
      if (i > 0 && redirect_valid) nr++;
      ex_stall = (i < 3);
      tick();
    end
    ex_stall = 0;
    n_chk++; if (nf != 5 || nr != 0) begin n_fail++; $display("FAIL stall_flush_len: got fl=%0d extra_rv=%0d want 5/0", nf, nr); end
  endtask

  task automatic test_reset_flush;
    logic t;
    logic [31:0] e;
    fire(7'b1100011, 3'b100, 32'h800, 0, 1, t);
    tick();
    idle();
    e = exp_q.pop_front();
    n_chk++; if (redirect_valid !== 1'b1 || redirect_pc !== e) begin n_fail++; $display("FAIL rstfl_redirect: got %b/%h want 1/%h", redirect_valid, redirect_pc, e); end
    rst = 1;
    tick();
    rst = 0;
    exp_bc = 0; exp_btc = 0;
    n_chk++; if (redirect_valid !== 1'b0 || {flush_if, flush_id} !== 2'b00 || redirect_pc !== 32'h0) begin n_fail++; $display("FAIL rstfl_abort: got rv=%b fl=%b%b pc=%h want 0/00/0", redirect_valid, flush_if, flush_id, redirect_pc); end
`ifdef BRANCH_STATS_EN
    n_chk++; if (br_count !== exp_bc || br_taken_count !== exp_btc) begin n_fail++; $display("FAIL rstfl_stats: got %0d/%0d want 0/0", br_count, br_taken_count); end
`endif
    tick();
    n_chk++; if (redirect_valid !== 1'b0 || flush_if !== 1'b0) begin n_fail++; $display("FAIL rstfl_after: got rv=%b fl=%b want 0/0", redirect_valid, flush_if); end
  endtask

  initial begin
    test_reset();
    test_beq();
    test_bltu();
    test_jump();
    test_cond_table();
    test_flush_ignore();
    test_stall();
`ifdef BRANCH_STATS_EN
    n_chk++; if (br_count !== exp_bc || br_taken_count !== exp_btc) begin n_fail++; $display("FAIL stats: got %0d/%0d want %0d/%0d", br_count, br_taken_count, exp_bc, exp_btc); end
`endif
    test_reset_flush();
    n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
